// File: rtl/paddsb_serial_pkg.sv
// Shared definitions for the serial packed saturating adder: state encoding,
// nibble count and the saturation values produced on overflow.
package paddsb_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int         NIBBLES  = 4;
  localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);
  localparam logic [3:0] SAT_POS  = 4'h7;
  localparam logic [3:0] SAT_NEG  = 4'h8;

endpackage

// File: rtl/paddsb_serial_addsb_4bit.sv
// 4-bit signed saturating adder shared by every nibble of the serial unit.
module addsb_4bit
  import paddsb_serial_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  logic [3:0] raw;
  logic       ovf;

  always_comb begin
    raw = a + b;
    ovf = (a[3] == b[3]) && (raw[3] != a[3]);
    y   = raw;
    if (ovf) begin
      y = a[3] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/paddsb_serial.sv
// Sequential PADDSB: one nibble per cycle through a single shared addsb_4bit,
// five cycles from accepted start to the done pulse.
module paddsb_serial
  import paddsb_serial_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum,
  output logic [3:0]  Sat
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] sum_q, sum_d;
  logic [3:0]  sat_q, sat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] a_sh, b_sh;
  logic [3:0]  a_nib, b_nib, raw_nib, add_y;
  logic        nib_ovf;

  addsb_4bit u_add (
    .a (a_nib),
    .b (b_nib),
    .y (add_y)
  );

  always_comb begin
    a_sh    = a_q >> {idx_q, 2'b00};
    b_sh    = b_q >> {idx_q, 2'b00};
    a_nib   = a_sh[3:0];
    b_nib   = b_sh[3:0];
    // Overflow is re-derived here since the adder only returns the clamped value.
    raw_nib = a_nib + b_nib;
    nib_ovf = (a_nib[3] == b_nib[3]) && (raw_nib[3] != a_nib[3]);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = 2'd0;
          sat_d   = 4'b0000;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = add_y;
        sat_d[idx_q]               = nib_ovf;
        idx_d                      = idx_q + 2'd1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      sum_q   <= 16'h0000;
      sat_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Sat  = sat_q;

endmodule

// File: tb/tb_paddsb_serial.sv
// Directed bench for paddsb_serial: vector table, back-to-back starts and
// mid-operation reset.
module tb_paddsb_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        busy, done;
  logic [15:0] Sum;
  logic [3:0]  Sat;

  int n_cmp = 0;
  int n_err = 0;

  paddsb_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Sat   (Sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic [3:0]  sat;
  } vec_t;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: clamp signed nibble sums arithmetically.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] s, output logic [3:0] f);
    int x, y, t;
    logic [3:0] nb;
    s = 16'h0;
    f = 4'h0;
    for (int i = 0; i < 4; i++) begin
      x = (a >> (4 * i)) & 15;
      y = (b >> (4 * i)) & 15;
      if (x > 7) x -= 16;
      if (y > 7) y -= 16;
      t = x + y;
      if (t > 7) begin t = 7; f[i] = 1'b1; end
      if (t < -8) begin t = -8; f[i] = 1'b1; end
      nb = 4'(t);
      s = s | (16'(nb) << (4 * i));
    end
  endtask

  // Drives one operation and checks busy/done timing and the result.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] es, input logic [3:0] ef);
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      A = ~a;
      B = 16'hA5A5 ^ b;
      check({nm, " busy"}, 16'(busy), 16'h1);
      check({nm, " done_early"}, 16'(done), 16'h0);
    end
    @(negedge clk);
    check({nm, " done"}, 16'(done), 16'h1);
    check({nm, " busy_in_done"}, 16'(busy), 16'h0);
    check({nm, " sum"}, Sum, es);
    check({nm, " sat"}, 16'(Sat), 16'(ef));
  endtask

  vec_t vecs[6];
  logic [15:0] va[16], vb[16];
  logic [15:0] ms;
  logic [3:0]  mf;

  initial begin
    vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 4'b0000};
    vecs[1] = '{16'h7777, 16'h1111, 16'h7777, 4'b1111};
    vecs[2] = '{16'h8888, 16'h8888, 16'h8888, 4'b1111};
    vecs[3] = '{16'h7F81, 16'h1111, 16'h7092, 4'b1000};
    vecs[4] = '{16'h5678, 16'h9ABC, 16'hE028, 4'b0001};
    vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 4'b0000};

    rst = 1'b1;
    start = 1'b0;
    A = 16'h0;
    B = 16'h0;
    repeat (2) @(negedge clk);
    check("reset busy", 16'(busy), 16'h0);
    check("reset done", 16'(done), 16'h0);
    check("reset sum", Sum, 16'h0000);
    check("reset sat", 16'(Sat), 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].sat);
    end

    // Idle after done: pulse ends, results hold.
    @(negedge clk);
    check("idle done", 16'(done), 16'h0);
    check("idle busy", 16'(busy), 16'h0);
    check("hold sum", Sum, vecs[5].sum);
    run_op("hold_pre", 16'h7F81, 16'h1111, 16'h7092, 4'b1000);
    repeat (3) @(negedge clk);
    check("hold sum2", Sum, 16'h7092);
    check("hold sat2", 16'(Sat), 16'h8);

    // Back-to-back with start held high and operands changing every cycle.
    for (int k = 0; k < 16; k++) begin
      va[k] = 16'h0123 + 16'(k) * 16'h1111;
      vb[k] = 16'h7A5C ^ (16'(k) * 16'h0F0F);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("b2b done k%0d", k), 16'(done), 16'((k % 5) == 0));
        check($sformatf("b2b busy k%0d", k), 16'(busy), 16'((k % 5) != 0));
        if ((k % 5) == 0) begin
          model(va[k-5], vb[k-5], ms, mf);
          check($sformatf("b2b sum k%0d", k), Sum, ms);
          check($sformatf("b2b sat k%0d", k), 16'(Sat), 16'(mf));
        end
      end
      start = (k < 15);
      A = va[k];
      B = vb[k];
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b end done", 16'(done), 16'h0);

    // Reset during RUN cycle 2 discards the operation.
    @(negedge clk);
    start = 1'b1;
    A = 16'hFFFF;
    B = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst busy", 16'(busy), 16'h0);
    check("mid rst done", 16'(done), 16'h0);
    check("mid rst sum", Sum, 16'h0000);
    check("mid rst sat", 16'(Sat), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post rst no done", 16'(done), 16'h0);
    end
    run_op("after_rst", 16'h0001, 16'h000F, 16'h0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
